// File: rtl/cluster_sync_pkg.sv
// Shared types for the cluster sync path: per-cluster decisions, availability codes,
// sequencer states and a small popcount helper.
package cluster_sync_pkg;

  localparam int CLUSTER_COUNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    TX   = 2'd1,
    DROP = 2'd2
  } evt_ctrl_e;

  typedef enum logic [1:0] {
    E_NOT_AV = 2'd0,
    EHDR_AV  = 2'd1,
    M_AV     = 2'd2,
    EFTR_AV  = 2'd3
  } evt_avail_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_STALLED = 2'd2
  } seq_state_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/cluster_fifo_read_sequencer_if.sv
// Handshake bundle between the cluster FIFOs, the sync engine, the sequencer and the link port.
interface cluster_fifo_read_sequencer_if #(
  parameter int DATA_WIDTH     = 65,
  parameter int TOTAL_CLUSTERS = cluster_sync_pkg::CLUSTER_COUNT_DEFAULT,
  parameter int SEL_WIDTH      = 3,
  parameter int CNT_WIDTH      = 32
);
  logic [TOTAL_CLUSTERS-1:0][1:0]            evt_ctrl;
  logic [SEL_WIDTH-1:0]                      cluster_sel;
  logic [TOTAL_CLUSTERS-1:0][DATA_WIDTH-1:0] fifo_dout;
  logic [TOTAL_CLUSTERS-1:0]                 fifo_empty;
  logic [TOTAL_CLUSTERS-1:0]                 fifo_rd_en;
  logic [DATA_WIDTH-1:0]                     out_data;
  logic                                      out_valid;
  logic                                      out_ready;
  logic [CNT_WIDTH-1:0]                      tx_word_cnt;
  logic [CNT_WIDTH-1:0]                      drop_word_cnt;
  logic                                      stall_err;
  logic                                      busy;

  modport master (
    input  evt_ctrl, cluster_sel, fifo_dout, fifo_empty, out_ready,
    output fifo_rd_en, out_data, out_valid, tx_word_cnt, drop_word_cnt, stall_err, busy
  );

  modport slave (
    output evt_ctrl, cluster_sel, fifo_dout, fifo_empty, out_ready,
    input  fifo_rd_en, out_data, out_valid, tx_word_cnt, drop_word_cnt, stall_err, busy
  );
endinterface

// File: rtl/cluster_out_skid_buf.sv
// Two-entry in-order valid/ready buffer; head register drives the output directly so
// out_data cannot change while a word waits for out_ready.
module cluster_out_skid_buf #(
  parameter int DATA_WIDTH = 65
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  srst_n,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            buf_cnt
);

  logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  pop;

  assign pop       = valid_q && out_ready;
  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign buf_cnt   = cnt_q;

  // Next head/tail/count from push and pop; the caller never pushes into a full buffer.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (!srst_n) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = 2'd0;
    end else begin
      case ({push_valid, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_d = push_data;
            cnt_d  = 2'd1;
          end else begin
            tail_d = push_data;
            cnt_d  = 2'd2;
          end
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_d = push_data;
          end else begin
            head_d = tail_q;
            tail_d = push_data;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
    valid_d = (cnt_d != 2'd0);
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/cluster_fifo_read_sequencer.sv
// Applies WAIT/TX/DROP decisions to the cluster FIFOs: TX words go through the output
// buffer to the link, DROP words are discarded; traffic counters and a starvation watchdog.
module cluster_fifo_read_sequencer
  import cluster_sync_pkg::*;
#(
  parameter int DATA_WIDTH     = 65,
  parameter int TOTAL_CLUSTERS = CLUSTER_COUNT_DEFAULT,
  parameter int SEL_WIDTH      = 3,
  parameter int CNT_WIDTH      = 32,
  parameter int STALL_TIMEOUT  = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          srst_n,
  cluster_fifo_read_sequencer_if.master bus
);

  localparam int IDX_W   = (TOTAL_CLUSTERS > 1) ? $clog2(TOTAL_CLUSTERS) : 1;
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_TIMEOUT);

  logic                      in_reset, sel_ok, sel_is_tx, sel_empty, tx_pop;
  logic [IDX_W-1:0]          sel_idx;
  logic [TOTAL_CLUSTERS-1:0] drop_pop, rd_en;
  logic [1:0]                buf_cnt;

  seq_state_e           state_q, state_d;
  logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                 stall_err_q, stall_err_d;
  logic [CNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d, drop_cnt_q, drop_cnt_d;

  assign sel_ok  = bus.cluster_sel < SEL_WIDTH'(TOTAL_CLUSTERS);
  assign sel_idx = bus.cluster_sel[IDX_W-1:0];

  // Pop decisions; buf_cnt is a register so out_ready never reaches fifo_rd_en combinationally.
  always_comb begin
    in_reset  = !rst_n || !srst_n;
    sel_is_tx = 1'b0;
    sel_empty = 1'b1;
    if (sel_ok) begin
      sel_is_tx = (bus.evt_ctrl[sel_idx] == TX);
      sel_empty = bus.fifo_empty[sel_idx];
    end else begin
      sel_is_tx = 1'b0;
      sel_empty = 1'b1;
    end
    tx_pop   = sel_is_tx && !sel_empty && (buf_cnt < 2'd2) && !in_reset;
    drop_pop = '0;
    rd_en    = '0;
    for (int i = 0; i < TOTAL_CLUSTERS; i++) begin
      drop_pop[i] = (bus.evt_ctrl[i] == DROP) && !bus.fifo_empty[i] && !in_reset;
      rd_en[i]    = drop_pop[i] || (tx_pop && (sel_idx == IDX_W'(i)));
    end
  end

  cluster_out_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .srst_n     (srst_n),
    .push_valid (tx_pop),
    .push_data  (bus.fifo_dout[sel_idx]),
    .out_valid  (bus.out_valid),
    .out_data   (bus.out_data),
    .out_ready  (bus.out_ready),
    .buf_cnt    (buf_cnt)
  );

  // Sequencer FSM, traffic counters and starvation watchdog.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = '0;
    stall_err_d = stall_err_q;
    tx_cnt_d    = tx_cnt_q + CNT_WIDTH'(tx_pop);
    drop_cnt_d  = drop_cnt_q + CNT_WIDTH'(popcount32(32'(drop_pop)));
    if (!srst_n) begin
      state_d     = S_IDLE;
      stall_err_d = 1'b0;
      tx_cnt_d    = '0;
      drop_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_is_tx) state_d = S_ACTIVE;
          else           state_d = S_IDLE;
        end
        S_ACTIVE: begin
          if (!sel_is_tx)     state_d = S_IDLE;
          else if (sel_empty) state_d = S_STALLED;
          else                state_d = S_ACTIVE;
        end
        S_STALLED: begin
          if (!sel_is_tx) begin
            state_d = S_IDLE;
          end else if (!sel_empty) begin
            state_d = S_ACTIVE;
          end else begin
            state_d     = S_STALLED;
            stall_cnt_d = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + STALL_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
      if (stall_cnt_d == STALL_MAX) stall_err_d = 1'b1;
      else                          stall_err_d = stall_err_q;
    end
  end

  // Control and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
      tx_cnt_q    <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
      tx_cnt_q    <= tx_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign bus.fifo_rd_en    = rd_en;
  assign bus.tx_word_cnt   = tx_cnt_q;
  assign bus.drop_word_cnt = drop_cnt_q;
  assign bus.stall_err     = stall_err_q;
  assign bus.busy          = (state_q != S_IDLE) || (buf_cnt != 2'd0);

endmodule

// File: tb/tb_cluster_fifo_read_sequencer.sv
// Bench for cluster_fifo_read_sequencer: FWFT FIFO emulation, queue-based reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_cluster_fifo_read_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic srst_n;

  cluster_fifo_read_sequencer_if #(
    .DATA_WIDTH(65), .TOTAL_CLUSTERS(4), .SEL_WIDTH(3), .CNT_WIDTH(32)
  ) bus ();

  cluster_fifo_read_sequencer #(
    .DATA_WIDTH(65), .TOTAL_CLUSTERS(4), .SEL_WIDTH(3), .CNT_WIDTH(32), .STALL_TIMEOUT(1024)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .srst_n (srst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int accepts = 0;

  logic [64:0] envq [4][$];
  logic [64:0] mbuf [$];
  logic [31:0] m_tx, m_drop;
  bit          m_eng, m_starve, m_err;
  int          m_run;

  logic [3:0][1:0] st_evt;
  logic [2:0]      st_sel;
  logic            st_ready;
  logic            st_srst;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [64:0] rand65();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  task automatic model_clear();
    mbuf.delete();
    m_tx = 32'd0;
    m_drop = 32'd0;
    m_eng = 1'b0;
    m_starve = 1'b0;
    m_err = 1'b0;
    m_run = 0;
  endtask

  // One clock cycle: drive at negedge, check 1ns later, advance model and FIFOs.
  task automatic cycle();
    bit in_rst, sel_ok, sel_tx, sel_empty, tx_pop;
    int s, ndrop;
    logic [3:0] exp_rd;
    bus.evt_ctrl    = st_evt;
    bus.cluster_sel = st_sel;
    bus.out_ready   = st_ready;
    srst_n          = st_srst;
    for (int i = 0; i < 4; i++) begin
      bus.fifo_empty[i] = (envq[i].size() == 0);
      bus.fifo_dout[i]  = (envq[i].size() == 0) ? rand65() : envq[i][0];
    end
    #1;
    in_rst = !rst_n || !st_srst;
    s = int'(st_sel);
    sel_ok = (s < 4);
    sel_tx = 1'b0;
    sel_empty = 1'b1;
    if (sel_ok) begin
      sel_tx    = (st_evt[s] == 2'd1);
      sel_empty = (envq[s].size() == 0);
    end
    tx_pop = !in_rst && sel_tx && !sel_empty && (mbuf.size() < 2);
    exp_rd = 4'd0;
    ndrop = 0;
    for (int i = 0; i < 4; i++) begin
      if (!in_rst && st_evt[i] == 2'd2 && envq[i].size() != 0) begin
        exp_rd[i] = 1'b1;
        ndrop++;
      end
    end
    if (tx_pop) exp_rd[s] = 1'b1;

    chk("out_valid", 128'(bus.out_valid), 128'(mbuf.size() != 0));
    if (mbuf.size() != 0) chk("out_data", 128'(bus.out_data), 128'(mbuf[0]));
    chk("fifo_rd_en", 128'(bus.fifo_rd_en), 128'(exp_rd));
    chk("tx_word_cnt", 128'(bus.tx_word_cnt), 128'(m_tx));
    chk("drop_word_cnt", 128'(bus.drop_word_cnt), 128'(m_drop));
    chk("stall_err", 128'(bus.stall_err), 128'(m_err));
    chk("busy", 128'(bus.busy), 128'(m_eng || mbuf.size() != 0));
    if (rst_n && bus.out_valid && st_ready) accepts++;

    if (in_rst) begin
      model_clear();
    end else begin
      if (st_ready && mbuf.size() != 0) void'(mbuf.pop_front());
      if (tx_pop) mbuf.push_back(envq[s][0]);
      m_tx   = m_tx + 32'(tx_pop);
      m_drop = m_drop + 32'(ndrop);
      if (!m_eng) begin
        if (sel_tx) m_eng = 1'b1;
      end else if (!sel_tx) begin
        m_eng = 1'b0; m_starve = 1'b0; m_run = 0;
      end else if (!m_starve) begin
        if (sel_empty) m_starve = 1'b1;
      end else if (!sel_empty) begin
        m_starve = 1'b0; m_run = 0;
      end else begin
        if (m_run < 1024) m_run++;
        if (m_run == 1024) m_err = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (exp_rd[i]) void'(envq[i].pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic srst_pulse();
    st_srst = 1'b0;
    cycle();
    st_srst = 1'b1;
    accepts = 0;
  endtask

  task automatic clear_env();
    for (int i = 0; i < 4; i++) envq[i].delete();
  endtask

  task automatic fill(input int c, input int n, input logic [64:0] base);
    for (int k = 0; k < n; k++) envq[c].push_back(base + 65'(k));
  endtask

  initial begin
    rst_n = 1'b0;
    srst_n = 1'b1;
    st_srst = 1'b1;
    st_evt = '0;
    st_sel = 3'd0;
    st_ready = 1'b1;
    model_clear();
    @(negedge clk);
    cycle();
    chk("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("reset_tx_cnt", 128'(bus.tx_word_cnt), 128'(32'd0));
    rst_n = 1'b1;
    run(2);

    // Single TX cluster streaming at full rate.
    srst_pulse();
    fill(1, 8, 65'h1_0000_0000_0000_0100);
    st_evt = {2'd0, 2'd0, 2'd1, 2'd0};
    st_sel = 3'd1;
    st_ready = 1'b1;
    run(14);
    chk("s1_tx_cnt", 128'(bus.tx_word_cnt), 128'(32'd8));
    chk("s1_accepts", 128'(accepts), 128'(8));

    // Backpressure holds the buffer full and stops popping.
    srst_pulse();
    fill(1, 8, 65'h0_AAAA_0000_0000_0000);
    st_ready = 1'b1;
    run(3);
    st_ready = 1'b0;
    run(2);
    chk("s2_rd_en_stopped", 128'(bus.fifo_rd_en), 128'(4'd0));
    run(2);
    st_ready = 1'b1;
    run(12);
    chk("s2_tx_cnt", 128'(bus.tx_word_cnt), 128'(32'd8));
    chk("s2_accepts", 128'(accepts), 128'(8));

    // TX on cluster 0 with concurrent drops on clusters 2 and 3.
    srst_pulse();
    clear_env();
    fill(0, 4, 65'h0_0000_0000_0000_C000);
    fill(2, 3, 65'h1_DDDD_0000_0000_0200);
    fill(3, 3, 65'h1_DDDD_0000_0000_0300);
    st_evt = {2'd2, 2'd2, 2'd0, 2'd1};
    st_sel = 3'd0;
    run(10);
    chk("s3_drop_cnt", 128'(bus.drop_word_cnt), 128'(32'd6));
    chk("s3_tx_cnt", 128'(bus.tx_word_cnt), 128'(32'd4));
    chk("s3_accepts", 128'(accepts), 128'(4));

    // Invalid selection: nothing moves.
    srst_pulse();
    for (int i = 0; i < 4; i++) fill(i, 2, 65'(i * 16));
    st_evt = {2'd1, 2'd1, 2'd1, 2'd1};
    st_sel = 3'd4;
    run(6);
    chk("s4_out_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("s4_rd_en", 128'(bus.fifo_rd_en), 128'(4'd0));
    chk("s4_busy", 128'(bus.busy), 128'(1'b0));

    // Starvation on cluster 2 sets the sticky flag; soft clear removes it.
    srst_pulse();
    clear_env();
    st_evt = {2'd0, 2'd1, 2'd0, 2'd0};
    st_sel = 3'd2;
    run(1000);
    chk("s5_no_err_yet", 128'(bus.stall_err), 128'(1'b0));
    run(30);
    chk("s5_err_set", 128'(bus.stall_err), 128'(1'b1));
    fill(2, 2, 65'h0_0000_5555_0000_0000);
    run(10);
    chk("s5_err_sticky", 128'(bus.stall_err), 128'(1'b1));
    srst_pulse();
    chk("s5_err_cleared", 128'(bus.stall_err), 128'(1'b0));

    // Async reset with two words buffered, then clean restart.
    srst_pulse();
    clear_env();
    fill(1, 8, 65'h1_0000_6666_0000_0000);
    st_evt = {2'd0, 2'd0, 2'd1, 2'd0};
    st_sel = 3'd1;
    st_ready = 1'b0;
    run(4);
    rst_n = 1'b0;
    #1;
    chk("s6_async_valid", 128'(bus.out_valid), 128'(1'b0));
    chk("s6_async_rd_en", 128'(bus.fifo_rd_en), 128'(4'd0));
    chk("s6_async_tx_cnt", 128'(bus.tx_word_cnt), 128'(32'd0));
    model_clear();
    cycle();
    rst_n = 1'b1;
    st_ready = 1'b1;
    accepts = 0;
    run(14);
    chk("s6_tx_cnt", 128'(bus.tx_word_cnt), 128'(32'd6));
    chk("s6_accepts", 128'(accepts), 128'(6));

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(7) == 0) begin
        for (int i = 0; i < 4; i++) st_evt[i] = 2'($urandom_range(3));
      end
      if ($urandom_range(15) == 0) st_sel = 3'($urandom_range(5));
      st_ready = ($urandom_range(99) < 70);
      st_srst = ($urandom_range(199) != 0);
      for (int i = 0; i < 4; i++) begin
        if (envq[i].size() < 6 && $urandom_range(3) == 0) envq[i].push_back(rand65());
      end
      cycle();
    end
    st_srst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
